// File: rtl/placar_pkg.sv
// Shared constants for the scoreboard display paths: active-low 7-segment
// patterns (bit order gfedcba) and the scan phase encodings.
package placar_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Scan phase: bit 1 selects the group (score/timer), bit 0 the digit.
    typedef enum logic [1:0] {
        FASE_PLACAR_DEZ = 2'b00,
        FASE_PLACAR_UNI = 2'b01,
        FASE_CRONO_DEZ  = 2'b10,
        FASE_CRONO_UNI  = 2'b11
    } fase_t;

endpackage

// File: rtl/bcd_para_7seg.sv
// Combinational BCD nibble to active-low 7-segment (gfedcba) decoder.
// Nibbles 10..15 are shown as a dash so bad data is visible on the board.
module bcd_para_7seg
    import placar_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one digit.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/gerador_varredura_display.sv
// Scan timing and digit data for the 4-digit multiplexed scoreboard display.
// A prescaler steps a 2-bit phase at SCAN_HZ; the registered segment pattern
// follows the new phase on the same edge so anodes and segments switch
// together. Score and timer are snapshotted at the start of every frame to
// avoid tearing.
// Optional build macro GERADOR_VARREDURA_BLANK_EN: blanks the segments for
// BLANK_CYCLES clocks after each phase step (anti-ghosting).
module gerador_varredura_display
    import placar_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 240,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] placar_bcd,
    input  logic [7:0] cronometro_bcd,
    output logic       scan_hi,
    output logic       scan_lo,
    output logic [6:0] segmentos,
    output logic       frame_start
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = $clog2(DIV);

    if (DIV < 2) begin : g_div_invalido
        $error("gerador_varredura_display: CLK_HZ/SCAN_HZ must be at least 2");
    end
    if (BLANK_CYCLES >= DIV) begin : g_blank_invalido
        $error("gerador_varredura_display: BLANK_CYCLES must be less than CLK_HZ/SCAN_HZ");
    end

    logic [PW-1:0] prescaler;
    logic          tick;
    fase_t         fase;
    fase_t         fase_prox;
    logic [7:0]    snap_placar;
    logic [7:0]    snap_crono;
    logic [3:0]    digito;
    logic [6:0]    seg_digito;

    assign tick      = (prescaler == PW'(DIV - 1));
    assign fase_prox = fase_t'(fase + 2'd1);
    assign scan_hi   = fase[1];
    assign scan_lo   = fase[0];

    // Free-running prescaler, 0..DIV-1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            prescaler <= '0;
        else if (tick)
            prescaler <= '0;
        else
            prescaler <= prescaler + PW'(1);
    end

    // Phase step, frame snapshot and frame-start pulse on each tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fase        <= FASE_PLACAR_DEZ;
            snap_placar <= 8'h00;
            snap_crono  <= 8'h00;
            frame_start <= 1'b0;
        end else if (tick) begin
            fase        <= fase_prox;
            frame_start <= (fase_prox == FASE_PLACAR_DEZ);
            if (fase_prox == FASE_PLACAR_DEZ) begin
                snap_placar <= placar_bcd;
                snap_crono  <= cronometro_bcd;
            end
        end else begin
            frame_start <= 1'b0;
        end
    end

    // Digit for the phase being entered; the first digit of a frame comes
    // straight from the live input because the snapshot loads on that edge.
    always_comb begin
        digito = 4'd0;
        case (fase_prox)
            FASE_PLACAR_DEZ: digito = placar_bcd[7:4];
            FASE_PLACAR_UNI: digito = snap_placar[3:0];
            FASE_CRONO_DEZ:  digito = snap_crono[7:4];
            FASE_CRONO_UNI:  digito = snap_crono[3:0];
            default:         digito = 4'd0;
        endcase
    end

    bcd_para_7seg u_decod (
        .bcd (digito),
        .seg (seg_digito)
    );

`ifdef GERADOR_VARREDURA_BLANK_EN
    localparam int BW = $clog2(BLANK_CYCLES + 2);

    logic [BW-1:0] blank_cnt;
    logic [6:0]    seg_pend;

    // Segment register with a blank window after each tick; the decoded
    // digit is held in seg_pend until the window closes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            segmentos <= SEG_OFF;
            seg_pend  <= SEG_OFF;
            blank_cnt <= '0;
        end else if (tick) begin
            seg_pend <= seg_digito;
            if (BLANK_CYCLES == 0) begin
                segmentos <= seg_digito;
                blank_cnt <= '0;
            end else begin
                segmentos <= SEG_OFF;
                blank_cnt <= BW'(BLANK_CYCLES);
            end
        end else if (blank_cnt == BW'(1)) begin
            segmentos <= seg_pend;
            blank_cnt <= '0;
        end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - BW'(1);
        end
    end
`else
    // Segment register switches directly with the phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            segmentos <= SEG_OFF;
        else if (tick)
            segmentos <= seg_digito;
    end
`endif

endmodule

// File: tb/tb_gerador_varredura_display.sv
// Scoreboard bench for gerador_varredura_display (CLK_HZ=16, SCAN_HZ=4,
// BLANK_CYCLES=2). The driver predicts every phase step from the frame rules
// and queues it; the monitor pops an entry each time the scan phase moves.
module tb_gerador_varredura_display;

    localparam int DIV = 4;
`ifdef GERADOR_VARREDURA_BLANK_EN
    localparam int BLANK_TB = 2;
`else
    localparam int BLANK_TB = 0;
`endif
    localparam logic [6:0] OFF = 7'b1111111;
    localparam logic [6:0] TAB [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    typedef struct {
        int         borda;
        logic [1:0] fase;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] placar_bcd = 8'h00;
    logic [7:0] cronometro_bcd = 8'h00;
    logic       scan_hi, scan_lo;
    logic [6:0] segmentos;
    logic       frame_start;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    int   borda_n = 0;

    // model state
    int         n;
    logic [7:0] snap_p, snap_c;

    // monitor state
    logic [1:0] prev_fase = 2'b00;
    int         tick_borda = 0;
    logic [6:0] cur_seg = OFF;

    gerador_varredura_display #(
        .CLK_HZ       (16),
        .SCAN_HZ      (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .placar_bcd     (placar_bcd),
        .cronometro_bcd (cronometro_bcd),
        .scan_hi        (scan_hi),
        .scan_lo        (scan_lo),
        .segmentos      (segmentos),
        .frame_start    (frame_start)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) borda_n <= 0;
        else          borda_n <= borda_n + 1;
    end

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, got, want, $time);
        end
    endtask

    // One clock of stimulus; if the coming edge is a tick edge, predict it.
    task automatic ciclo(input logic [7:0] p, input logic [7:0] c);
        int         k;
        logic [1:0] f;
        logic [3:0] dig [4];
        exp_t       e;
        placar_bcd     = p;
        cronometro_bcd = c;
        n++;
        if (n % DIV == 0) begin
            k = n / DIV;
            f = 2'(k % 4);
            if (f == 2'd0) begin
                snap_p = p;
                snap_c = c;
            end
            dig[0] = snap_p[7:4];
            dig[1] = snap_p[3:0];
            dig[2] = snap_c[7:4];
            dig[3] = snap_c[3:0];
            e.borda = n;
            e.fase  = f;
            e.seg   = TAB[dig[f]];
            e.fs    = (f == 2'd0);
            q.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic ciclo_aleatorio();
        logic [7:0] p, c;
        p = placar_bcd;
        c = cronometro_bcd;
        if ($urandom_range(7) == 0) p = 8'($urandom_range(255));
        if ($urandom_range(7) == 0) c = 8'($urandom_range(255));
        ciclo(p, c);
    endtask

    // Monitor: every phase movement consumes one prediction; segments and
    // frame_start are checked on every cycle.
    always @(negedge clock) begin
        exp_t       e;
        logic [1:0] fase_now;
        logic [6:0] exp_seg;
        if (!reset_n) begin
            prev_fase  = 2'b00;
            tick_borda = 0;
            cur_seg    = OFF;
        end else begin
            fase_now = {scan_hi, scan_lo};
            if (fase_now != prev_fase) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_phase_step: got phase %0d at edge %0d expected no step", fase_now, borda_n);
                end else begin
                    e = q.pop_front();
                    check("tick_edge", borda_n, e.borda);
                    check("phase", {30'd0, fase_now}, {30'd0, e.fase});
                    check("frame_start_tick", {31'd0, frame_start}, {31'd0, e.fs});
                    cur_seg = e.seg;
                end
                tick_borda = borda_n;
                prev_fase  = fase_now;
            end else begin
                check("frame_start_idle", {31'd0, frame_start}, 32'd0);
            end
            exp_seg = (tick_borda != 0 && (borda_n - tick_borda) < BLANK_TB) ? OFF : cur_seg;
            check("segmentos", {25'd0, segmentos}, {25'd0, exp_seg});
        end
    end

    initial begin
        int guard;
        n      = 0;
        snap_p = 8'h00;
        snap_c = 8'h00;
        #2 reset_n = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("reset_scan", {30'd0, scan_hi, scan_lo}, 32'd0);
            check("reset_seg", {25'd0, segmentos}, {25'd0, OFF});
            check("reset_fs", {31'd0, frame_start}, 32'd0);
        end
        #1 reset_n = 1'b1;

        // scan sequence and digit mapping
        repeat (53) ciclo(8'h42, 8'h59);
        // mid-frame change: must only appear from the next frame
        repeat (40) ciclo(8'h77, 8'h59);
        // invalid timer tens
        repeat (32) ciclo(8'h77, 8'hA3);
        // random traffic
        repeat (300) ciclo_aleatorio();

        // run to phase 10, one clock into the prescale, then reset async
        guard = 0;
        do begin
            ciclo_aleatorio();
            guard++;
        end while (!((n % DIV == 1) && ((n / DIV) % 4 == 2)) && guard < 64);
        check("reach_phase_10", {30'd0, scan_hi, scan_lo}, 32'd2);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_scan", {30'd0, scan_hi, scan_lo}, 32'd0);
        check("async_reset_seg", {25'd0, segmentos}, {25'd0, OFF});
        check("async_reset_fs", {31'd0, frame_start}, 32'd0);
        q.delete();
        n      = 0;
        snap_p = 8'h00;
        snap_c = 8'h00;
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b1;
        repeat (150) ciclo_aleatorio();

        @(negedge clock);
        #1;
        check("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
